// File: rtl/adsr_envelope_gen2.sv
// adsr_envelope_gen2: parametrised ADSR envelope generator with legato/hard retrigger and end-of-cycle pulse.
// Define ADSR_EXP_CURVE_EN for exponential decay/release steps (attack always stays linear).
module adsr_envelope_gen2 #(
    parameter int ENV_W          = 12,
    parameter int RATE_W         = 8,
    parameter int PRESCALE_SHIFT = 8,
    parameter int EXP_SHIFT      = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              gate,
    input  logic              trig,
    input  logic              retrig_mode,
    input  logic [RATE_W-1:0] attack_rate,
    input  logic [RATE_W-1:0] decay_rate,
    input  logic [7:0]        sustain_level,
    input  logic [RATE_W-1:0] release_rate,
    output logic [ENV_W-1:0]  env_out,
    output logic [7:0]        env_out8,
    output logic [2:0]        state_out,
    output logic              busy,
    output logic              eoc
);
    localparam int CNT_W = RATE_W + PRESCALE_SHIFT;
    localparam logic [ENV_W:0]   MAX_EXT = {1'b0, {ENV_W{1'b1}}};
    localparam logic [ENV_W:0]   ONE_EXT = {{ENV_W{1'b0}}, 1'b1};
    localparam logic [ENV_W-1:0] ENV_ONE = {{(ENV_W-1){1'b0}}, 1'b1};
    localparam logic [ENV_W-1:0] ENV_ZERO = {ENV_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ATTACK  = 3'd1,
        ST_DECAY   = 3'd2,
        ST_SUSTAIN = 3'd3,
        ST_RELEASE = 3'd4
    } state_t;

    state_t            state_r;
    state_t            state_nxt_s;
    logic [ENV_W-1:0]  env_r;
    logic [ENV_W-1:0]  env_nxt_s;
    logic [ENV_W-1:0]  sus_full_s;
    logic [CNT_W-1:0]  cnt_r;
    logic [CNT_W-1:0]  cnt_reload_s;
    logic              gate_prev_r;
    logic              gate_rise_s;
    logic              tick_s;
    logic              eoc_nxt_s;
    logic [RATE_W-1:0] rate_cur_s;
    logic [RATE_W-1:0] rate_nxt_s;
    logic [ENV_W:0]    env_ext_s;
    logic [ENV_W:0]    sus_ext_s;
    logic [ENV_W:0]    dec_step_s;
    logic [ENV_W:0]    rel_step_s;
    logic              att_done_s;
    logic              dec_done_s;
    logic              rel_done_s;

    // Curve step: span shifted down by EXP_SHIFT, never less than one LSB.
    function automatic logic [ENV_W:0] curve_step(input logic [ENV_W:0] span);
        logic [ENV_W:0] s;
        s = span >> EXP_SHIFT;
        if (s == {(ENV_W+1){1'b0}}) begin
            s = ONE_EXT;
        end else begin
            s = span >> EXP_SHIFT;
        end
        return s;
    endfunction

    // Prescaler rate belonging to a state; IDLE and SUSTAIN never step on a tick.
    function automatic logic [RATE_W-1:0] rate_of(input state_t st, input logic [RATE_W-1:0] a,
                                                  input logic [RATE_W-1:0] d, input logic [RATE_W-1:0] r);
        logic [RATE_W-1:0] v;
        case (st)
            ST_ATTACK:  v = a;
            ST_DECAY:   v = d;
            ST_RELEASE: v = r;
            default:    v = {RATE_W{1'b0}};
        endcase
        return v;
    endfunction

    generate
        if (ENV_W > 8) begin : g_sus_wide
            assign sus_full_s = {sustain_level, sustain_level[7 -: ENV_W-8]};
        end else begin : g_sus_narrow
            assign sus_full_s = sustain_level;
        end
    endgenerate

    assign gate_rise_s = gate & ~gate_prev_r;
    assign env_out     = env_r;
    assign env_out8    = env_r[ENV_W-1 -: 8];
    assign state_out   = state_r;

    // Step sizes and end-of-phase compares, all one bit wider than the envelope so nothing wraps.
    always_comb begin
        env_ext_s = {1'b0, env_r};
        sus_ext_s = {1'b0, sus_full_s};
`ifdef ADSR_EXP_CURVE_EN
        if (env_ext_s > sus_ext_s) begin
            dec_step_s = curve_step(env_ext_s - sus_ext_s);
        end else begin
            dec_step_s = ONE_EXT;
        end
        rel_step_s = curve_step(env_ext_s);
`else
        dec_step_s = ONE_EXT;
        rel_step_s = ONE_EXT;
`endif
        att_done_s = (env_ext_s + ONE_EXT) >= MAX_EXT;
        dec_done_s = env_ext_s <= (sus_ext_s + dec_step_s);
        rel_done_s = env_ext_s <= rel_step_s;
    end

    // Tick generation; the reload uses the rate of the state in force after this edge.
    always_comb begin
        rate_cur_s   = rate_of(state_r, attack_rate, decay_rate, release_rate);
        rate_nxt_s   = rate_of(state_nxt_s, attack_rate, decay_rate, release_rate);
        tick_s       = (cnt_r == {CNT_W{1'b0}}) || (rate_cur_s == {RATE_W{1'b0}});
        cnt_reload_s = (CNT_W'(rate_nxt_s) << PRESCALE_SHIFT) - CNT_ONE;
    end

    // Next state and envelope: gate low beats retrigger, retrigger beats tick.
    always_comb begin
        state_nxt_s = state_r;
        env_nxt_s   = env_r;
        eoc_nxt_s   = 1'b0;
        if (!gate) begin
            case (state_r)
                ST_IDLE: env_nxt_s = ENV_ZERO;
                ST_ATTACK, ST_DECAY, ST_SUSTAIN: state_nxt_s = ST_RELEASE;
                ST_RELEASE: begin
                    if (tick_s && rel_done_s) begin
                        state_nxt_s = ST_IDLE;
                        env_nxt_s   = ENV_ZERO;
                        eoc_nxt_s   = 1'b1;
                    end else if (tick_s) begin
                        env_nxt_s = env_r - rel_step_s[ENV_W-1:0];
                    end else begin
                        env_nxt_s = env_r;
                    end
                end
                default: begin
                    state_nxt_s = ST_IDLE;
                    env_nxt_s   = ENV_ZERO;
                end
            endcase
        end else if (gate_rise_s || trig || (state_r == ST_IDLE)) begin
            state_nxt_s = ST_ATTACK;
            if (retrig_mode || (state_r == ST_IDLE)) begin
                env_nxt_s = ENV_ZERO;
            end else begin
                env_nxt_s = env_r;
            end
        end else begin
            case (state_r)
                ST_ATTACK: begin
                    if (tick_s && att_done_s) begin
                        state_nxt_s = ST_DECAY;
                        env_nxt_s   = MAX_EXT[ENV_W-1:0];
                    end else if (tick_s) begin
                        env_nxt_s = env_r + ENV_ONE;
                    end else begin
                        env_nxt_s = env_r;
                    end
                end
                ST_DECAY: begin
                    if (tick_s && dec_done_s) begin
                        state_nxt_s = ST_SUSTAIN;
                        env_nxt_s   = sus_full_s;
                    end else if (tick_s) begin
                        env_nxt_s = env_r - dec_step_s[ENV_W-1:0];
                    end else begin
                        env_nxt_s = env_r;
                    end
                end
                ST_SUSTAIN: env_nxt_s = sus_full_s;
                ST_RELEASE: begin
                    if (tick_s && rel_done_s) begin
                        state_nxt_s = ST_IDLE;
                        env_nxt_s   = ENV_ZERO;
                        eoc_nxt_s   = 1'b1;
                    end else if (tick_s) begin
                        env_nxt_s = env_r - rel_step_s[ENV_W-1:0];
                    end else begin
                        env_nxt_s = env_r;
                    end
                end
                default: begin
                    state_nxt_s = ST_IDLE;
                    env_nxt_s   = ENV_ZERO;
                end
            endcase
        end
    end

    // Envelope FSM registers, registered status outputs and the tick prescaler.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            env_r       <= ENV_ZERO;
            eoc         <= 1'b0;
            busy        <= 1'b0;
            gate_prev_r <= 1'b0;
            cnt_r       <= {CNT_W{1'b0}};
        end else begin
            state_r     <= state_nxt_s;
            env_r       <= env_nxt_s;
            eoc         <= eoc_nxt_s;
            busy        <= (state_nxt_s != ST_IDLE);
            gate_prev_r <= gate;
            if ((state_nxt_s != state_r) || tick_s) begin
                cnt_r <= cnt_reload_s;
            end else begin
                cnt_r <= cnt_r - CNT_ONE;
            end
        end
    end
endmodule

// File: tb/tb_adsr_envelope_gen2.sv
// Bench for adsr_envelope_gen2 (ENV_W=12, RATE_W=8, PRESCALE_SHIFT=8): directed scenarios
// followed by random gate/trig traffic, all checked each clock against an integer phase model.
module tb_adsr_envelope_gen2;
    localparam int P_IDLE = 0, P_ATT = 1, P_DEC = 2, P_SUS = 3, P_REL = 4;
    localparam int MAXV   = 4095;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        gate;
    logic        trig;
    logic        retrig_mode;
    logic [7:0]  attack_rate;
    logic [7:0]  decay_rate;
    logic [7:0]  sustain_level;
    logic [7:0]  release_rate;
    logic [11:0] env_out;
    logic [7:0]  env_out8;
    logic [2:0]  state_out;
    logic        busy;
    logic        eoc;

    int n_vec = 0;
    int n_err = 0;
    int m_ph, m_lev, m_eoc, m_gprev, m_elapsed, m_period;

    adsr_envelope_gen2 #(.ENV_W(12), .RATE_W(8), .PRESCALE_SHIFT(8), .EXP_SHIFT(4)) dut (
        .clk(clk), .rst_n(rst_n), .gate(gate), .trig(trig), .retrig_mode(retrig_mode),
        .attack_rate(attack_rate), .decay_rate(decay_rate), .sustain_level(sustain_level),
        .release_rate(release_rate), .env_out(env_out), .env_out8(env_out8),
        .state_out(state_out), .busy(busy), .eoc(eoc)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            if (n_err <= 25) $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Clocks between steps for a phase: rate * 256, or every clock when the rate is zero.
    function automatic int period_of(input int ph);
        int r;
        r = (ph == P_ATT) ? int'(attack_rate) : (ph == P_DEC) ? int'(decay_rate) :
            (ph == P_REL) ? int'(release_rate) : 0;
        return (r == 0) ? 1 : r * 256;
    endfunction

    function automatic int dec_amount(input int lev, input int sus);
`ifdef ADSR_EXP_CURVE_EN
        int d;
        d = (lev > sus) ? (lev - sus) / 16 : 0;
        return (d < 1) ? 1 : d;
`else
        return 1;
`endif
    endfunction

    function automatic int rel_amount(input int lev);
`ifdef ADSR_EXP_CURVE_EN
        return (lev / 16 < 1) ? 1 : lev / 16;
`else
        return 1;
`endif
    endfunction

    task automatic model_reset();
        m_ph = P_IDLE; m_lev = 0; m_eoc = 0; m_gprev = 0; m_elapsed = 0; m_period = 1;
    endtask

    task automatic model_edge();
        int nph, nlev, tk, rise, susv, st;
        susv = int'(sustain_level) * 16 + int'(sustain_level) / 16;
        rise = (gate && !m_gprev) ? 1 : 0;
        tk   = (m_elapsed == m_period - 1) ? 1 : 0;
        nph  = m_ph; nlev = m_lev; m_eoc = 0;
        if (!gate && (m_ph == P_ATT || m_ph == P_DEC || m_ph == P_SUS)) begin
            nph = P_REL;
        end else if (gate && (rise == 1 || trig || m_ph == P_IDLE)) begin
            nph = P_ATT;
            if (retrig_mode || m_ph == P_IDLE) nlev = 0;
        end else if (m_ph == P_SUS) begin
            nlev = susv;
        end else if (tk == 1) begin
            case (m_ph)
                P_ATT: begin
                    if (m_lev + 1 >= MAXV) begin nlev = MAXV; nph = P_DEC; end
                    else nlev = m_lev + 1;
                end
                P_DEC: begin
                    st = dec_amount(m_lev, susv);
                    if (m_lev <= susv + st) begin nlev = susv; nph = P_SUS; end
                    else nlev = m_lev - st;
                end
                P_REL: begin
                    st = rel_amount(m_lev);
                    if (m_lev <= st) begin nlev = 0; nph = P_IDLE; m_eoc = 1; end
                    else nlev = m_lev - st;
                end
                default: nlev = 0;
            endcase
        end
        if (nph != m_ph || tk == 1) begin
            m_elapsed = 0;
            m_period  = period_of(nph);
        end else begin
            m_elapsed++;
        end
        m_ph = nph; m_lev = nlev; m_gprev = gate ? 1 : 0;
    endtask

    task automatic compare_all();
        chk("env_out", 32'(env_out), 32'(m_lev));
        chk("env_out8", 32'(env_out8), 32'(m_lev / 16));
        chk("state_out", 32'(state_out), 32'(m_ph));
        chk("busy", 32'(busy), (m_ph != P_IDLE) ? 32'd1 : 32'd0);
        chk("eoc", 32'(eoc), 32'(m_eoc));
    endtask

    task automatic step();
        @(posedge clk);
        if (rst_n) model_edge(); else model_reset();
        #1;
        compare_all();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        rst_n = 1'b0; gate = 1'b0; trig = 1'b0; retrig_mode = 1'b0;
        attack_rate = 8'd0; decay_rate = 8'd0; release_rate = 8'd0; sustain_level = 8'h80;
        model_reset();
        #2;
        compare_all();
        repeat (2) step();
        rst_n = 1'b1;
        step();

        // A=D=0, sustain 0x80: attack length, then settle in sustain at 0x808.
        gate = 1'b1;
        n = 0;
        do begin step(); n++; end while (state_out != 3'd2 && n < 5000);
        chk("t1_attack_clks", 32'(n), 32'd4096);
        n = 0;
        do begin step(); n++; end while (state_out != 3'd3 && n < 5000);
        chk("t1_sus_env", 32'(env_out), 32'h808);
        chk("t1_sus_env8", 32'(env_out8), 32'h80);
        chk("t1_sus_state", 32'(state_out), 32'd3);

        // Release from 0x808 at R=0.
        gate = 1'b0;
        n = 0;
        do begin step(); n++; end while (eoc != 1'b1 && n < 3000);
`ifndef ADSR_EXP_CURVE_EN
        chk("t3_release_clks", 32'(n), 32'd2057);
`endif
        chk("t3_busy", 32'(busy), 32'd0);
        step();
        chk("t3_eoc_one_clk", 32'(eoc), 32'd0);

        // Retrigger from RELEASE at 0x400, legato then hard.
        gate = 1'b1;
        n = 0;
        do begin step(); n++; end while (state_out != 3'd3 && n < 9000);
        gate = 1'b0;
        n = 0;
        do begin step(); n++; end while (!(m_ph == P_REL && m_lev == 32'h400) && n < 3000);
        gate = 1'b1; retrig_mode = 1'b0;
        step();
        chk("t4_legato_env", 32'(env_out), 32'h400);
        chk("t4_legato_state", 32'(state_out), 32'd1);
        gate = 1'b0;
        step();
        gate = 1'b1; retrig_mode = 1'b1;
        step();
        chk("t4_hard_env", 32'(env_out), 32'd0);
        chk("t4_hard_state", 32'(state_out), 32'd1);

        // trig with gate low in RELEASE is ignored.
        release_rate = 8'd1;
        gate = 1'b0;
        step();
        trig = 1'b1;
        step();
        trig = 1'b0;
        chk("t5_trig_gate_low", 32'(state_out), 32'd4);
        n = 0;
        do begin step(); n++; end while (state_out != 3'd0 && n < 1000);
        release_rate = 8'd0;

        // Gate fall and trig on the same clock in SUSTAIN: release wins.
        sustain_level = 8'hFF;
        gate = 1'b1;
        n = 0;
        do begin step(); n++; end while (state_out != 3'd3 && n < 5000);
        chk("t5_sus_ff_env", 32'(env_out), 32'hFFF);
        gate = 1'b0; trig = 1'b1;
        step();
        trig = 1'b0;
        chk("t5_fall_trig", 32'(state_out), 32'd4);

        // Async reset mid-attack at 0x3FF.
        gate = 1'b1; retrig_mode = 1'b1;
        step();
        repeat (1023) step();
        chk("t6_pre_env", 32'(env_out), 32'h3FF);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_rst_env", 32'(env_out), 32'd0);
        chk("t6_rst_state", 32'(state_out), 32'd0);
        chk("t6_rst_busy", 32'(busy), 32'd0);
        chk("t6_rst_eoc", 32'(eoc), 32'd0);
        model_reset();
        repeat (2) step();
        rst_n = 1'b1;
        step();
        chk("t6_after_rst", 32'(state_out), 32'd1);

        // Random gate/trig/mode traffic.
        for (int s = 0; s < 14; s++) begin
            int len;
            if (m_ph == P_IDLE) begin
                attack_rate  = ($urandom_range(0, 3) == 0) ? 8'd1 : 8'd0;
                decay_rate   = ($urandom_range(0, 3) == 0) ? 8'd1 : 8'd0;
                release_rate = ($urandom_range(0, 3) == 0) ? 8'd1 : 8'd0;
            end
            sustain_level = 8'($urandom_range(0, 255));
            retrig_mode   = 1'($urandom_range(0, 1));
            gate          = ~gate;
            len           = $urandom_range(1, 2500);
            for (int c = 0; c < len; c++) begin
                trig = ($urandom_range(0, 149) == 0);
                if ($urandom_range(0, 299) == 0) gate = ~gate;
                step();
            end
            trig = 1'b0;
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
